// File: rtl/processor_system_vjtag_pkg.sv
// Shared types and constants for the virtual JTAG scan master.
// IR codes match the Nios II debug module's virtual IR decode.
package processor_system_vjtag_pkg;

  localparam int VJ_DW  = 38;
  localparam int VJ_IRW = 2;

  localparam logic [1:0] IR_OCIMEM    = 2'd0;
  localparam logic [1:0] IR_TRACEMEM  = 2'd1;
  localparam logic [1:0] IR_BREAK     = 2'd2;
  localparam logic [1:0] IR_TRACECTRL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SHIFT,
    ST_UDR,
    ST_DONE
  } vj_state_e;

  // Zero and oversize lengths both mean a full-width scan.
  function automatic logic [5:0] eff_len(
    input logic [5:0] len,
    input logic [5:0] dw
  );
    return (len == 6'd0 || len > dw) ? dw : len;
  endfunction

endpackage

// File: rtl/processor_system_vjtag_tck_gen.sv
// TCK divider: low half-period first, restarts from low when re-enabled.
// tck_rise/tck_fall flag the clk edge on which tck changes.
module processor_system_vjtag_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tck,
  output logic tck_rise,
  output logic tck_fall
);

  localparam int CW = $clog2(2 * TCK_DIV);
  localparam logic [CW-1:0] LAST    = CW'(2 * TCK_DIV - 1);
  localparam logic [CW-1:0] HALF    = CW'(TCK_DIV);
  localparam logic [CW-1:0] RISE_AT = CW'(TCK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tck_q, tck_d;

  always_comb begin
    cnt_d = '0;
    tck_d = 1'b0;
    if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      tck_d = (cnt_d >= HALF);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

  assign tck      = tck_q;
  assign tck_rise = en && (cnt_q == RISE_AT);
  assign tck_fall = en && (cnt_q == LAST);

endmodule

// File: rtl/processor_system_vjtag_scan_master.sv
// Host end of the 2-bit-IR virtual JTAG link: plays UIR/CDR/SDR/UDR
// for one command on a generated TCK and returns the captured TDO bits.
module processor_system_vjtag_scan_master
  import processor_system_vjtag_pkg::*;
#(
  parameter int DW      = VJ_DW,
  parameter int IRW     = VJ_IRW,
  parameter int TCK_DIV = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [IRW-1:0] cmd_ir,
  input  logic [DW-1:0]  cmd_data,
  input  logic [5:0]     cmd_len,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [DW-1:0]  rsp_data,
  output logic           vji_tck,
  output logic           vji_tdi,
  output logic           vji_sdr,
  output logic           vji_cdr,
  output logic           vji_rti,
  output logic           vji_uir,
  output logic           vji_udr,
  output logic [IRW-1:0] vji_ir_in,
  input  logic           vji_tdo
);

  vj_state_e      state_q, state_d;
  logic [DW-1:0]  sr_q, sr_d;
  logic [DW-1:0]  cap_q, cap_d;
  logic [DW-1:0]  rsp_q, rsp_d;
  logic [5:0]     len_q, len_d;
  logic [5:0]     left_q, left_d;
  logic [IRW-1:0] ir_q, ir_d;
  logic           tdi_q, tdi_d;
  logic           uir_q, uir_d;
  logic           cdr_q, cdr_d;
  logic           sdr_q, sdr_d;
  logic           udr_q, udr_d;
  logic           rti_q, rti_d;
  logic           tck_en, tck, tck_rise, tck_fall;

  assign tck_en = (state_q == ST_UIR) || (state_q == ST_CDR) ||
                  (state_q == ST_SHIFT) || (state_q == ST_UDR);

  processor_system_vjtag_tck_gen #(
    .TCK_DIV (TCK_DIV)
  ) u_tck (
    .clk      (clk),
    .rst      (reset),
    .en       (tck_en),
    .tck      (tck),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall)
  );

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cap_d   = cap_q;
    rsp_d   = rsp_q;
    len_d   = len_q;
    left_d  = left_q;
    ir_d    = ir_q;
    tdi_d   = tdi_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d = ST_UIR;
          ir_d    = cmd_ir;
          sr_d    = cmd_data;
          cap_d   = '0;
          len_d   = eff_len(cmd_len, 6'(DW));
          left_d  = len_d;
        end
      end
      ST_UIR: if (tck_fall) state_d = ST_CDR;
      ST_CDR: if (tck_fall) state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (tck_rise) begin
          cap_d = {vji_tdo, cap_q[DW-1:1]};
          sr_d  = {1'b0, sr_q[DW-1:1]};
        end
        if (tck_fall) begin
          left_d = left_q - 6'd1;
          if (left_q == 6'd1) state_d = ST_UDR;
        end
      end
      ST_UDR: begin
        if (tck_fall) begin
          state_d = ST_DONE;
          rsp_d   = cap_q >> (6'(DW) - len_q);
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
          ir_d    = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // TDI moves only as the low phase begins.
    if (tck_fall) tdi_d = (state_d == ST_SHIFT) && sr_q[0];
    uir_d = (state_d == ST_UIR);
    cdr_d = (state_d == ST_CDR);
    sdr_d = (state_d == ST_SHIFT);
    udr_d = (state_d == ST_UDR);
    rti_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cap_q   <= '0;
      rsp_q   <= '0;
      len_q   <= '0;
      left_q  <= '0;
      ir_q    <= '0;
      tdi_q   <= 1'b0;
      uir_q   <= 1'b0;
      cdr_q   <= 1'b0;
      sdr_q   <= 1'b0;
      udr_q   <= 1'b0;
      rti_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cap_q   <= cap_d;
      rsp_q   <= rsp_d;
      len_q   <= len_d;
      left_q  <= left_d;
      ir_q    <= ir_d;
      tdi_q   <= tdi_d;
      uir_q   <= uir_d;
      cdr_q   <= cdr_d;
      sdr_q   <= sdr_d;
      udr_q   <= udr_d;
      rti_q   <= rti_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_DONE);
  assign rsp_data  = rsp_q;
  assign vji_tck   = tck;
  assign vji_tdi   = tdi_q;
  assign vji_uir   = uir_q;
  assign vji_cdr   = cdr_q;
  assign vji_sdr   = sdr_q;
  assign vji_udr   = udr_q;
  assign vji_rti   = rti_q;
  assign vji_ir_in = ir_q;

endmodule

// File: tb/tb_processor_system_vjtag_scan_master.sv
// Bench for the virtual JTAG scan master: timeline model checked every
// cycle, a shift-register slave on the link, and literal scenario pins.
module tb_processor_system_vjtag_scan_master;

  localparam int DW = 38;
  localparam int D  = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_ir = '0;
  logic [DW-1:0] cmd_data = '0;
  logic [5:0]    cmd_len = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic          vji_tck, vji_tdi, vji_sdr, vji_cdr;
  logic          vji_rti, vji_uir, vji_udr;
  logic [1:0]    vji_ir_in;
  logic          vji_tdo;

  processor_system_vjtag_scan_master #(
    .DW (DW), .IRW (2), .TCK_DIV (D)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_ir    (cmd_ir),
    .cmd_data  (cmd_data),
    .cmd_len   (cmd_len),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .vji_tck   (vji_tck),
    .vji_tdi   (vji_tdi),
    .vji_sdr   (vji_sdr),
    .vji_cdr   (vji_cdr),
    .vji_rti   (vji_rti),
    .vji_uir   (vji_uir),
    .vji_udr   (vji_udr),
    .vji_ir_in (vji_ir_in),
    .vji_tdo   (vji_tdo)
  );

  always #5 clk = ~clk;

  // Slave: 38-bit shift register, TDI in at the MSB, TDO from bit 0.
  logic [DW-1:0] slv, slv_init = '0;
  logic          slv_load = 1'b0;
  logic          tie1 = 1'b0;

  always @(posedge vji_tck or posedge slv_load) begin
    if (slv_load) slv <= slv_init;
    else if (vji_sdr) slv <= {vji_tdi, slv[DW-1:1]};
  end

  assign vji_tdo = tie1 ? 1'b1 : slv[0];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  bit            busy = 0;
  int            t0, ml, k, p, total;
  int            rises, sdr_r, last_lat, last_rises, last_sdr;
  logic [DW-1:0] m_data, exp_rsp, last_rsp, tdi_bits, last_tdi;
  logic [1:0]    m_ir;
  logic          prev_tck = 1'b0;
  logic          hi;
  logic [3:0]    exp_str;

  function automatic logic [DW-1:0] lmask(input int l);
    logic [DW-1:0] a;
    a = '1;
    return a >> (DW - l);
  endfunction

  function automatic int eff(input logic [5:0] len);
    return (len == 6'd0 || int'(len) > DW) ? DW : int'(len);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Per-cycle model: from acceptance, cycle offset k maps to
  // TCK period p=(k-1)/(2D); periods are UIR, CDR, L x SDR, UDR.
  task automatic monitor();
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        busy = 0;
        chk("reset_outs",
            {cmd_ready, vji_rti, rsp_valid, vji_tck, vji_tdi,
             vji_uir, vji_cdr, vji_sdr, vji_udr, vji_ir_in},
            11'b110_0000_0000);
        chk("reset_rsp_data", rsp_data, '0);
      end else if (!busy) begin
        chk("idle_outs",
            {cmd_ready, vji_rti, rsp_valid, vji_tck,
             vji_uir, vji_cdr, vji_sdr, vji_udr, vji_ir_in},
            10'b11_0000_0000);
        if (cmd_valid) begin
          busy     = 1;
          t0       = cyc;
          m_ir     = cmd_ir;
          m_data   = cmd_data;
          ml       = eff(cmd_len);
          exp_rsp  = (tie1 ? '1 : slv) & lmask(ml);
          rises    = 0;
          sdr_r    = 0;
          tdi_bits = '0;
        end
      end else begin
        k     = cyc - t0;
        total = (ml + 3) * 2 * D;
        if (k <= total) begin
          p  = (k - 1) / (2 * D);
          hi = ((k - 1) % (2 * D)) >= D;
          exp_str = {p == 0, p == 1, p >= 2 && p < ml + 2, p == ml + 2};
          chk("scan_hs", {cmd_ready, rsp_valid}, 2'b00);
          chk("scan_tck", vji_tck, hi);
          chk("scan_strobes", {vji_uir, vji_cdr, vji_sdr, vji_udr},
              exp_str);
          chk("scan_ir", vji_ir_in, m_ir);
          if (p >= 2 && p < ml + 2) chk("scan_tdi", vji_tdi, m_data[p-2]);
          if (vji_tck && !prev_tck) begin
            rises++;
            if (vji_sdr) begin
              tdi_bits[sdr_r] = vji_tdi;
              sdr_r++;
            end
          end
        end else begin
          if (k == total + 1) begin
            last_lat   = k;
            last_rises = rises;
            last_sdr   = sdr_r;
            last_tdi   = tdi_bits;
            chk("tck_rises", rises, ml + 3);
            chk("sdr_rises", sdr_r, ml);
          end
          chk("done_outs",
              {rsp_valid, cmd_ready, vji_tck,
               vji_uir, vji_cdr, vji_sdr, vji_udr},
              7'b100_0000);
          chk("done_rsp_data", rsp_data, exp_rsp);
          chk("done_ir", vji_ir_in, m_ir);
          last_rsp = rsp_data;
          if (rsp_ready) busy = 0;
        end
      end
      prev_tck = vji_tck;
    end
  endtask

  task automatic start_cmd(input logic [1:0] ir, input logic [DW-1:0] data,
                           input logic [5:0] len, input logic tie,
                           input logic [DW-1:0] init);
    @(posedge clk);
    #2;
    slv_init  = init;
    tie1      = tie;
    slv_load  = 1'b1;
    #1;
    slv_load  = 1'b0;
    cmd_ir    = ir;
    cmd_data  = data;
    cmd_len   = len;
    cmd_valid = 1'b1;
    @(posedge clk);
    #2;
    cmd_valid = 1'b0;
  endtask

  task automatic finish_cmd(input logic [DW-1:0] data, input logic [5:0] len,
                            input logic [DW-1:0] init, input int hold);
    int n;
    int l;
    l = eff(len);
    n = 0;
    while (n < 600) begin
      @(posedge clk);
      #2;
      n++;
      if (rsp_valid) break;
      rsp_ready = 1'($urandom_range(0, 1));
      cmd_valid = 1'($urandom_range(0, 1));
    end
    rsp_ready = 1'b0;
    chk("rsp_arrives", rsp_valid, 1'b1);
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1;
      @(posedge clk);
      #2;
    end
    rsp_ready = 1'b1;
    cmd_valid = 1'b0;
    @(posedge clk);
    #2;
    rsp_ready = 1'b0;
    chk("slave_contents", slv,
        (init >> l) | ((data & lmask(l)) << (DW - l)));
  endtask

  task automatic run_cmd(input logic [1:0] ir, input logic [DW-1:0] data,
                         input logic [5:0] len, input logic tie,
                         input logic [DW-1:0] init, input int hold);
    start_cmd(ir, data, len, tie, init);
    finish_cmd(data, len, init, hold);
  endtask

  initial begin
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (2) @(posedge clk);

    run_cmd(2'b01, 38'h2A_5555_5555, 6'd38, 1'b0, 38'h15_AAAA_AAAA, 0);
    chk("full_rsp", last_rsp, 38'h15_AAAA_AAAA);
    chk("full_slave", slv, 38'h2A_5555_5555);
    chk("full_latency", last_lat, 165);
    chk("full_rises", last_rises, 41);

    run_cmd(2'b10, 38'hA5, 6'd8, 1'b1, 38'h0, 10);
    chk("short_rsp", last_rsp, 38'h00_0000_00FF);
    chk("short_tdi_seq", last_tdi[7:0], 8'hA5);
    chk("short_sdr_rises", last_sdr, 8);

    start_cmd(2'b11, 38'h3F_0F0F_1234, 6'd38, 1'b0, 38'h12_3456_789A);
    repeat (89) @(posedge clk);
    #2;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    run_cmd(2'b00, 38'h9, 6'd4, 1'b0, 38'h2B_CDEF_0123, 0);
    chk("after_reset_latency", last_lat, 29);
    chk("after_reset_rsp", last_rsp, 38'h3);

    run_cmd(2'b10, 38'h01_2345_6789, 6'd0, 1'b0, 38'h3C_3C3C_3C3C, 1);
    chk("len0_rises", last_rises, 41);
    run_cmd(2'b01, 38'h2F_FFFF_0000, 6'd50, 1'b0, 38'h11_1111_1111, 2);
    chk("len50_rises", last_rises, 41);

    for (int i = 0; i < 14; i++) begin
      run_cmd(2'($urandom), {6'($urandom), 32'($urandom)},
              6'($urandom_range(0, 63)), 1'($urandom_range(0, 3) == 0),
              {6'($urandom), 32'($urandom)}, $urandom_range(0, 4));
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
